// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and FSM state encoding for the memory arbiter
package mem_arbiter_pkg;

    localparam int ARCH_BITS        = 32;
    localparam int MEMORY_LINE_BITS = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_ACK     = 3'd4
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and line-memory bus seen by the arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ARCH_BITS = mem_arbiter_pkg::ARCH_BITS,
    parameter int LINE_BITS = MEMORY_LINE_BITS
);
    logic                 i_req;
    logic [ARCH_BITS-1:0] i_addr;
    logic                 i_ack;
    logic [LINE_BITS-1:0] i_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [ARCH_BITS-1:0] d_addr;
    logic [LINE_BITS-1:0] d_wdata;
    logic                 d_ack;
    logic [LINE_BITS-1:0] d_rdata;

    logic [ARCH_BITS-1:0] mem_rAddr;
    logic [ARCH_BITS-1:0] mem_wAddr;
    logic [LINE_BITS-1:0] mem_wData;
    logic                 mem_WE;
    logic [LINE_BITS-1:0] mem_rData;
    logic                 mem_rValid;
    logic                 mem_wDone;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_rAddr, mem_wAddr, mem_wData, mem_WE,
        input  mem_rData, mem_rValid, mem_wDone
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_rAddr, mem_wAddr, mem_wData, mem_WE,
        output mem_rData, mem_rValid, mem_wDone
    );

endinterface

// File: rtl/mem_rr_arb2.sv
// rtl/mem_rr_arb2.sv - combinational two-way round-robin picker (0 = fetch, 1 = data)
module mem_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = 1'b0;
        case (req_i)
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ~last_grant_i;
            default: grant_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the single-ported line memory between fetch and data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ARCH_BITS      = mem_arbiter_pkg::ARCH_BITS,
    parameter int LINE_BITS      = MEMORY_LINE_BITS,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_BITS        = 5
) (
    input  logic                clk,
    input  logic                rst,
    mem_arbiter_if.slave        bus,
    output logic                busy,
    output logic                timeout_err
);

    arb_state_e           state_q, state_d;
    logic                 last_grant_q;
    logic                 owner_q;
    logic                 txn_we_q;
    logic [ARCH_BITS-1:0] txn_addr_q;
    logic [LINE_BITS-1:0] txn_wdata_q;
    logic [LINE_BITS-1:0] i_rdata_q;
    logic [LINE_BITS-1:0] d_rdata_q;
    logic [TO_BITS-1:0]   to_cnt_q;
    logic                 timeout_err_q;

    logic                 grant_valid;
    logic                 grant_id;
    logic                 load;
    logic                 rd_done;
    logic                 forced;
    logic                 expired;
    logic [LINE_BITS-1:0] rd_value;

    assign expired  = (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES));
    assign rd_value = bus.mem_rValid ? bus.mem_rData : '0;

    mem_rr_arb2 u_rr (
        .req_i         ({bus.d_req, bus.i_req}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        rd_done       = 1'b0;
        forced        = 1'b0;
        bus.mem_rAddr = txn_addr_q;
        bus.mem_wAddr = txn_addr_q;
        bus.mem_wData = '0;
        bus.mem_WE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Inverted address on both ports makes the memory restart its delay counters
                bus.mem_rAddr = ~txn_addr_q;
                bus.mem_wAddr = ~txn_addr_q;
                state_d       = txn_we_q ? ST_WAIT_WR : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (bus.mem_rValid) begin
                    rd_done = 1'b1;
                    state_d = ST_ACK;
                end else if (expired) begin
                    rd_done = 1'b1;
                    forced  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_WAIT_WR: begin
                bus.mem_wData = txn_wdata_q;
                bus.mem_WE    = 1'b1;
                if (bus.mem_wDone) begin
                    state_d = ST_ACK;
                end else if (expired) begin
                    forced  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) last_grant_q <= grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWNER_I;
            txn_we_q    <= 1'b0;
            txn_addr_q  <= '0;
            txn_wdata_q <= '0;
        end else if (load) begin
            owner_q     <= grant_id;
            txn_we_q    <= grant_id & bus.d_we;
            txn_addr_q  <= grant_id ? bus.d_addr : bus.i_addr;
            txn_wdata_q <= bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT_RD || state_q == ST_WAIT_WR) begin
            to_cnt_q <= to_cnt_q + TO_BITS'(1);
        end
    end

    // A forced read completion returns zero rather than whatever the memory is presenting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (rd_done) begin
                if (owner_q == OWNER_D) d_rdata_q <= rd_value;
                else                    i_rdata_q <= rd_value;
            end
            if (forced) timeout_err_q <= 1'b1;
        end
    end

    assign bus.i_ack   = (state_q == ST_ACK) && (owner_q == OWNER_I);
    assign bus.d_ack   = (state_q == ST_ACK) && (owner_q == OWNER_D);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench with line-memory model and reference scoreboard
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int LW       = 128;
    localparam int TMO      = 16;
    localparam int RD_DELAY = 7;
    localparam int WR_DELAY = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic timeout_err;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ARCH_BITS(AW), .LINE_BITS(LW)) bus ();

    mem_arbiter #(
        .ARCH_BITS      (AW),
        .LINE_BITS      (LW),
        .TIMEOUT_CYCLES (TMO),
        .TO_BITS        (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] init_line(input int k);
        if (k == 4) return {4{32'hA5A5A5A5}};
        return {32'(k), 32'hC0DE0000 | 32'(k), ~32'(k), 32'(k * 7)};
    endfunction

    function automatic int line_of(input logic [AW-1:0] a);
        return int'(a[14:4]);
    endfunction

    // Line memory: each delay counter restarts whenever its address (or WE) changes
    logic [LW-1:0] mem     [0:2047];
    logic [LW-1:0] ref_mem [0:2047];
    logic [AW-1:0] prev_raddr = '0;
    logic [AW-1:0] prev_waddr = '0;
    logic          prev_we    = 1'b0;
    int            rcnt       = 0;
    int            wcnt       = 0;
    logic          stub       = 1'b0;

    initial begin
        for (int k = 0; k < 2048; k++) begin
            mem[k]     = init_line(k);
            ref_mem[k] = init_line(k);
        end
    end

    always @(posedge clk) begin
        if (bus.mem_wDone) mem[line_of(bus.mem_wAddr)] = bus.mem_wData;
        if (bus.mem_rAddr != prev_raddr) rcnt = 0;
        else if (rcnt < RD_DELAY)        rcnt = rcnt + 1;
        if (bus.mem_wAddr != prev_waddr || bus.mem_WE != prev_we) wcnt = 0;
        else if (wcnt < WR_DELAY)                                 wcnt = wcnt + 1;
        prev_raddr = bus.mem_rAddr;
        prev_waddr = bus.mem_wAddr;
        prev_we    = bus.mem_WE;
    end

    assign bus.mem_rValid = !stub && (rcnt == RD_DELAY) && (bus.mem_rAddr == prev_raddr);
    assign bus.mem_wDone  = bus.mem_WE && prev_we && (wcnt == WR_DELAY) && (bus.mem_wAddr == prev_waddr);
    assign bus.mem_rData  = mem[line_of(bus.mem_rAddr)];

    // Reference model: expected rdata/timeout_err follow from the acks and a reference memory
    logic [LW-1:0] exp_i = '0;
    logic [LW-1:0] exp_d = '0;
    logic          exp_terr = 1'b0;
    logic          prev_rvalid = 1'b0, prev_wdone = 1'b0, prev_iack = 1'b0, prev_dack = 1'b0;
    int            ack_order[$];
    int            we_cycles = 0, busy_cycles = 0, n_dack = 0;
    logic [AW-1:0] watch_addr = '0;
    logic          saw_inv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_i = '0; exp_d = '0; exp_terr = 1'b0;
            prev_rvalid = 1'b0; prev_wdone = 1'b0; prev_iack = 1'b0; prev_dack = 1'b0;
        end else begin
            if (bus.i_ack) begin
                check("i_ack_after_done", LW'(prev_rvalid | stub), LW'(1));
                exp_i = stub ? '0 : ref_mem[line_of(bus.i_addr)];
                if (stub) exp_terr = 1'b1;
                ack_order.push_back(0);
            end
            if (bus.d_ack) begin
                n_dack++;
                check("d_ack_after_done", LW'(bus.d_we ? prev_wdone : (prev_rvalid | stub)), LW'(1));
                if (bus.d_we) ref_mem[line_of(bus.d_addr)] = bus.d_wdata;
                else          exp_d = stub ? '0 : ref_mem[line_of(bus.d_addr)];
                if (stub) exp_terr = 1'b1;
                ack_order.push_back(1);
            end
            check("acks_exclusive", LW'(bus.i_ack & bus.d_ack), LW'(0));
            check("i_ack_one_cycle", LW'(bus.i_ack & prev_iack), LW'(0));
            check("d_ack_one_cycle", LW'(bus.d_ack & prev_dack), LW'(0));
            check("i_rdata", bus.i_rdata, exp_i);
            check("d_rdata", bus.d_rdata, exp_d);
            check("timeout_err", LW'(timeout_err), LW'(exp_terr));
            if (bus.mem_WE) begin
                we_cycles++;
                check("we_for_data_write",
                      LW'({bus.d_req & bus.d_we, bus.mem_wAddr == bus.d_addr, bus.mem_wData == bus.d_wdata}),
                      LW'(3'b111));
            end
            if (busy) busy_cycles++;
            if (bus.mem_rAddr == ~watch_addr) saw_inv = 1'b1;
            prev_rvalid = bus.mem_rValid;
            prev_wdone  = bus.mem_wDone;
            prev_iack   = bus.i_ack;
            prev_dack   = bus.d_ack;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit dport, input int max, output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (dport ? bus.d_ack : bus.i_ack) break;
            if (lat >= max) begin
                check(dport ? "d_ack_within_bound" : "i_ack_within_bound", LW'(0), LW'(1));
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, LW'({bus.i_ack, bus.d_ack, bus.mem_WE, busy, timeout_err}), LW'(0));
        check({tag, "_i_rdata"}, bus.i_rdata, '0);
        check({tag, "_d_rdata"}, bus.d_rdata, '0);
        check({tag, "_mem_addr"}, LW'({bus.mem_rAddr, bus.mem_wAddr}), LW'(0));
        check({tag, "_mem_wData"}, bus.mem_wData, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dack_before;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // reset state
        tick(3);
        check_all_zero("reset");
        rst = 1'b1;
        tick(2);

        // simultaneous requests: strict alternation i,d,i,d,...
        ack_order.delete();
        bus.i_addr = 32'h200; bus.d_addr = 32'h300; bus.d_we = 1'b0;
        bus.i_req  = 1'b1;    bus.d_req  = 1'b1;
        fork
            begin
                int l;
                for (int k = 0; k < 4; k++) begin
                    wait_ack(1'b0, 80, l);
                    tick(1);
                    bus.i_addr = 32'h200 + 32'(16 * (k + 1));
                    if (k == 3) bus.i_req = 1'b0;
                end
            end
            begin
                int l;
                for (int k = 0; k < 4; k++) begin
                    wait_ack(1'b1, 80, l);
                    tick(1);
                    bus.d_addr = 32'h300 + 32'(16 * (k + 1));
                    if (k == 3) bus.d_req = 1'b0;
                end
            end
        join
        tick(2);
        check("rr_ack_count", LW'(ack_order.size()), LW'(8));
        for (int k = 0; k < ack_order.size(); k++)
            check($sformatf("rr_order_%0d", k), LW'(ack_order[k]), LW'(k % 2));

        // single fetch of line 4
        we_cycles = 0; busy_cycles = 0;
        bus.i_addr = 32'h40; bus.i_req = 1'b1;
        wait_ack(1'b0, 40, lat);
        bus.i_req = 1'b0;
        check("fetch_latency", LW'(lat), LW'(11));
        check("fetch_data", bus.i_rdata, {4{32'hA5A5A5A5}});
        tick(2);
        check("fetch_no_we", LW'(we_cycles), LW'(0));
        check("fetch_busy_cycles", LW'(busy_cycles), LW'(11));

        // data write then read of the same line
        we_cycles = 0;
        bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 128'h1234; bus.d_req = 1'b1;
        wait_ack(1'b1, 40, lat);
        bus.d_req = 1'b0;
        check("write_latency", LW'(lat), LW'(9));
        tick(2);
        check("write_we_cycles", LW'(we_cycles), LW'(7));
        bus.d_we = 1'b0; bus.d_req = 1'b1;
        wait_ack(1'b1, 40, lat);
        bus.d_req = 1'b0;
        check("readback_latency", LW'(lat), LW'(11));
        check("readback_data", bus.d_rdata, 128'h1234);
        tick(2);

        // back-to-back fetches of the same line
        watch_addr = 32'h100;
        bus.i_addr = 32'h100; bus.i_req = 1'b1;
        wait_ack(1'b0, 40, lat);
        check("b2b_first_latency", LW'(lat), LW'(11));
        saw_inv = 1'b0;
        wait_ack(1'b0, 40, lat);
        bus.i_req = 1'b0;
        check("b2b_second_latency", LW'(lat), LW'(12));
        check("b2b_second_data", bus.i_rdata, init_line(16));
        check("b2b_setup_inverted_addr", LW'(saw_inv), LW'(1));
        tick(2);

        // memory never answers: forced completion after TMO+1 wait cycles
        stub = 1'b1;
        bus.i_addr = 32'h500; bus.i_req = 1'b1;
        wait_ack(1'b0, 40, lat);
        bus.i_req = 1'b0;
        check("timeout_latency", LW'(lat), LW'(2 + TMO + 1));
        check("timeout_rdata_zero", bus.i_rdata, '0);
        check("timeout_err_set", LW'(timeout_err), LW'(1));
        tick(1);
        stub = 1'b0;
        tick(2);
        bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_req = 1'b1;
        wait_ack(1'b1, 40, lat);
        bus.d_req = 1'b0;
        check("post_timeout_latency", LW'(lat), LW'(11));
        check("post_timeout_data", bus.d_rdata, 128'h1234);
        check("timeout_err_sticky", LW'(timeout_err), LW'(1));
        tick(2);

        // asynchronous reset in the middle of a write
        dack_before = n_dack;
        bus.d_we = 1'b1; bus.d_addr = 32'h600; bus.d_wdata = 128'hDEAD_BEEF; bus.d_req = 1'b1;
        tick(5);
        check("midwrite_we_high", LW'(bus.mem_WE), LW'(1));
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.d_req = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(15);
        check("aborted_no_ack", LW'(n_dack), LW'(dack_before));
        check("aborted_idle", LW'(busy), LW'(0));
        check("aborted_not_committed", mem[line_of(32'h600)], init_line(line_of(32'h600)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported line memory (32 KB, 16 B lines, fixed read/write delay) between the instruction-fetch port (read-only) and the data port (read/write).
- Round-robin arbitration. One transaction is in flight at a time.
- Guarantees the address/WE changes the memory needs to restart its delay counters, so back-to-back accesses to the same line never return stale rValid/wDone.
- Sits between the cache/fetch units and the memory module inside proc.

Parameters:
- ARCH_BITS, proc.ARCH_BITS (32), address width.
- LINE_BITS, proc.MEMORY_LINE_BITS (128), data line width.
- TIMEOUT_CYCLES, 16, max cycles in a wait state before forced completion.
- TO_BITS, 5, timeout counter width (must exceed log2 TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  ARCH_BITS  fetch line address.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid this cycle.
- i_rdata  out  LINE_BITS  fetched line.
- d_req  in  1  data request; d_we/d_addr/d_wdata held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ARCH_BITS  data line address.
- d_wdata  in  LINE_BITS  write line.
- d_ack  out  1  one-cycle pulse: data transaction complete.
- d_rdata  out  LINE_BITS  read line, valid with d_ack when d_we=0.
- mem_rAddr  out  ARCH_BITS  to memory rAddr.
- mem_wAddr  out  ARCH_BITS  to memory wAddr.
- mem_wData  out  LINE_BITS  to memory wData.
- mem_WE  out  1  to memory WE.
- mem_rData  in  LINE_BITS  from memory.
- mem_rValid  in  1  from memory.
- mem_wDone  in  1  from memory.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on any forced completion.

Behaviour:
- Reset (rst low, async): state=IDLE, last_grant=1 (port 0 wins the first tie), all outputs 0 (mem_WE=0, acks=0, rdata=0, busy=0, timeout_err=0). The timeout counter clears. In-flight work is abandoned without an ack; requesters must re-request after reset.
- Datapath registers: txn_addr, txn_wdata, txn_we, owner (0=i, 1=d). They load only on the IDLE->SETUP transition.
- States:
  - IDLE: no request -> stay. Requests present -> grant. Both requesting -> grant the port != last_grant. Load registers, update last_grant, go to SETUP.
  - SETUP (1 cycle): mem_rAddr=~txn_addr, mem_wAddr=~txn_addr, mem_WE=0. This forces both memory counters to restart. Next state is WAIT_WR if txn_we, else WAIT_RD.
  - WAIT_RD: mem_rAddr=txn_addr, mem_WE=0. When mem_rValid is sampled high, capture mem_rData into the owner's rdata register and go to ACK.
  - WAIT_WR: mem_wAddr=txn_addr, mem_wData=txn_wdata, mem_WE=1. When mem_wDone is sampled high, go to ACK. mem_WE drops to 0 in ACK, so the write commits exactly once.
  - ACK (1 cycle): pulse the owner's ack, mem_WE=0, then go to IDLE. A new grant needs at least IDLE+SETUP, so there are at least 2 cycles between successive memory transactions.
- rdata registers hold their value until the next read completion for that port.
- In IDLE and ACK, mem_rAddr/mem_wAddr = txn_addr (no stray toggling).
- Timeout: the counter clears on entering a wait state and increments each wait cycle. At TIMEOUT_CYCLES without rValid/wDone, go to ACK anyway, set timeout_err, and return rdata = 0.
- Nominal latency (memory read delay 7, write delay 5): req high in IDLE -> ack ~11 cycles for a read, ~9 for a write. The ack is exactly one cycle after rValid/wDone is sampled high.
- A requester dropping req before ack is illegal; the transaction completes regardless.
- The ungranted port waits. Strict alternation under contention means no starvation.
- Address bits above [14:4] pass through; the memory ignores them.

Decomposition:
- The proc package holds ARCH_BITS and MEMORY_LINE_BITS, plus a new state localparam set (IDLE, SETUP, WAIT_RD, WAIT_WR, ACK; 3-bit encoding).
- One sub-module, mem_rr_arb2: combinational 2-way round-robin picker. Inputs req[1:0] and last_grant; outputs grant_valid and grant_id.
- The FSM, datapath registers and timeout counter stay in mem_arbiter.

Test Plan:
- Single fetch i_addr=0x40 (memory preloaded line 4 = 0x...A5A5) -> one i_ack pulse; i_rdata=0x...A5A5; mem_WE never high; busy high from the cycle after req until ack.
- Data write d_addr=0x80, d_wdata=0x1234, then a data read of 0x80 -> the write is acked once (mem_WE high only in WAIT_WR). The read returns 0x1234, not the stale line, proving the SETUP counter restart.
- i_req and d_req asserted in the same cycle after reset, each repeated 4 times -> grants alternate i,d,i,d,... and each port gets exactly 4 acks.
- Two back-to-back reads of the same address 0x100 from the i port -> two separate acks, each exactly one cycle after mem_rValid sampled high; SETUP drives mem_rAddr=~0x100 between them.
- Memory stub that never raises rValid -> ack after TIMEOUT_CYCLES+1 wait cycles; timeout_err=1 and sticky; rdata=0; the next transaction proceeds normally.
- rst pulled low mid-WAIT_WR -> all outputs 0 immediately (async); state IDLE after release; no ack issued for the aborted write.
